machine_heap_alloc: RTL

- Heap allocator and write-port arbiter for the SKI reduction machine.
- Two requesters (0 = term loader, 1 = reduction engine) submit 63-bit SKI terms.
- The block grants one requester round-robin, encodes the term into a 64-bit heap word, writes it at the bump-pointer address, and returns the allocated address to the granted requester.
- It is the only writer of the heap memory.

---
 rtl/machine_heap_alloc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/machine_heap_alloc.sv
// Heap allocator and single write-port arbiter for the SKI reduction machine.
// Optional usage counters are compiled in with MACHINE_HEAP_STATS_EN.
//
// state | meaning
// IDLE  | arbitrate requesters, apply pending heap clear
// WRITE | heap write outstanding, hold until mem_wr_ready
// RESP  | one-cycle response pulse to the granted requester
module machine_heap_alloc #(
   parameter int ADDR_W     = 30,
   parameter int HEAP_LIMIT = 1048576
) (
   input  logic              system1000,
   input  logic              system1000_rst,
   input  logic              req0_valid,
   input  logic [62:0]       req0_term,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [ADDR_W-1:0] rsp0_addr,
   input  logic              req1_valid,
   input  logic [62:0]       req1_term,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [ADDR_W-1:0] rsp1_addr,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [63:0]       mem_wr_data,
   input  logic              mem_wr_ready,
   input  logic              heap_clear,
   output logic              heap_full,
   output logic [ADDR_W:0]   alloc_ptr
`ifdef MACHINE_HEAP_STATS_EN
   ,
   output logic [31:0]       alloc_count,
   output logic [31:0]       stall_count
`endif
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(HEAP_LIMIT);

   typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

   state_t      state, state_nxt;
   logic        clear_pend;
   logic        last_grant;
   logic        gnt;
   logic        grant_ok;
   logic        pick1;
   logic        accept;
   logic [62:0] term_sel;

   function automatic logic [63:0] encode(input logic [62:0] t);
      case (t[62:60])
         3'b000:  return {4'h0, 60'b0};
         3'b001:  return {4'h1, 60'b0};
         3'b010:  return {4'h2, 60'b0};
         3'b011:  return {4'h3, t[59:30], t[29:0]};
         default: return {4'h4, 28'b0, t[59:28]};
      endcase
   endfunction

   assign heap_full = (alloc_ptr == LIMIT);

   always_comb begin
      state_nxt  = state;
      grant_ok   = (state == IDLE) && !heap_full && !heap_clear && !clear_pend;
      // with both requesting, the one not served last wins
      pick1      = req1_valid && (!req0_valid || !last_grant);
      req0_ready = grant_ok && req0_valid && !pick1;
      req1_ready = grant_ok && pick1;
      accept     = req0_ready || req1_ready;
      term_sel   = pick1 ? req1_term : req0_term;
      case (state)
         IDLE:    if (accept) state_nxt = WRITE;
         WRITE:   if (mem_wr_ready) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         state       <= IDLE;
         alloc_ptr   <= '0;
         clear_pend  <= 1'b0;
         last_grant  <= 1'b1;
         gnt         <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         rsp0_valid  <= 1'b0;
         rsp0_addr   <= '0;
         rsp1_valid  <= 1'b0;
         rsp1_addr   <= '0;
      end else begin
         state      <= state_nxt;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (heap_clear || clear_pend) begin
                  alloc_ptr  <= '0;
                  clear_pend <= 1'b0;
               end else if (accept) begin
                  gnt         <= pick1;
                  last_grant  <= pick1;
                  mem_wr_data <= encode(term_sel);
                  mem_wr_addr <= alloc_ptr[ADDR_W-1:0];
                  mem_wr_en   <= 1'b1;
               end
            end
            WRITE: begin
               // a clear arriving mid-write waits until the write has landed
               if (heap_clear) clear_pend <= 1'b1;
               if (mem_wr_ready) begin
                  mem_wr_en <= 1'b0;
                  alloc_ptr <= alloc_ptr + 1'b1;
                  if (gnt) begin
                     rsp1_addr  <= mem_wr_addr;
                     rsp1_valid <= 1'b1;
                  end else begin
                     rsp0_addr  <= mem_wr_addr;
                     rsp0_valid <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (heap_clear) clear_pend <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MACHINE_HEAP_STATS_EN
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         alloc_count <= '0;
         stall_count <= '0;
      end else begin
         if (state == WRITE && mem_wr_ready && alloc_count != '1)
            alloc_count <= alloc_count + 1'b1;
         if (mem_wr_en && !mem_wr_ready && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end
`endif

endmodule
